// File: rtl/x_stack.sv
// x_stack: LIFO stack of X_SIZE-bit vectors answering the cpu's PUSH/POP stack port.
// Ports: clk_in clock; rst_n_in async active-low reset; clear_in sync flush;
//   push_data_in/push_valid_in/push_ready_out push handshake;
//   top_out/top_valid_out/pop_ready_in registered top and pop handshake;
//   count_out entries held (0..DEPTH); err_out sticky protocol error.
// Optional feature: define STACK_ERR_EN to build the sticky overflow/underflow error flag.
module x_stack #(
  parameter int X_SIZE = 1024,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear_in,
  input  logic [X_SIZE-1:0] push_data_in,
  input  logic              push_valid_in,
  output logic              push_ready_out,
  output logic [X_SIZE-1:0] top_out,
  output logic              top_valid_out,
  input  logic              pop_ready_in,
  output logic [CW-1:0]     count_out,
  output logic              err_out
);
  logic [X_SIZE-1:0] mem [DEPTH-1];
  logic [X_SIZE-1:0] top_q, top_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_fire, pop_fire;
  logic [AW-1:0]     wr_idx, rd_idx;
  assign push_ready_out = count_q != CW'(DEPTH);
  assign top_valid_out  = count_q != '0;
  assign push_fire      = push_valid_in & push_ready_out;
  assign pop_fire       = pop_ready_in & top_valid_out;
  // Indices wrap when count is too small; they are only used when in range.
  assign wr_idx         = AW'(count_q - CW'(1));
  assign rd_idx         = AW'(count_q - CW'(2));
  assign top_out        = top_q;
  assign count_out      = count_q;
  always_comb begin
    count_d = clear_in ? '0
            : (push_fire & !pop_fire) ? count_q + CW'(1)
            : (pop_fire & !push_fire) ? count_q - CW'(1)
            : count_q;
    // Push+pop together simply replaces the top; mem and count stay put.
    top_d = clear_in ? '0
          : push_fire ? push_data_in
          : pop_fire ? ((count_q == CW'(1)) ? '0 : mem[rd_idx])
          : top_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      count_q <= '0;
      top_q   <= '0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
    end
  always_ff @(posedge clk_in)
    if (!clear_in && push_fire && !pop_fire && top_valid_out) mem[wr_idx] <= top_q;
`ifdef STACK_ERR_EN
  logic err_q, err_d;
  always_comb
    err_d = clear_in ? 1'b0
          : err_q | (push_valid_in & !push_ready_out) | (pop_ready_in & !top_valid_out);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) err_q <= 1'b0;
    else err_q <= err_d;
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_x_stack.sv
// tb_x_stack: scoreboard bench for x_stack with directed push/pop/clear/reset vectors.
module tb_x_stack;
  localparam int W = 16;
  localparam int D = 16;
  localparam int CW = $clog2(D + 1);
`ifdef STACK_ERR_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          clear_in = 1'b0;
  logic [W-1:0]  push_data_in = '0;
  logic          push_valid_in = 1'b0;
  logic          push_ready_out;
  logic [W-1:0]  top_out;
  logic          top_valid_out;
  logic          pop_ready_in = 1'b0;
  logic [CW-1:0] count_out;
  logic          err_out;
  typedef struct {
    string        nm;
    int           cnt;
    logic [W-1:0] top;
    logic         err;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  x_stack #(.X_SIZE(W), .DEPTH(D)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clear_in(clear_in),
    .push_data_in(push_data_in), .push_valid_in(push_valid_in), .push_ready_out(push_ready_out),
    .top_out(top_out), .top_valid_out(top_valid_out), .pop_ready_in(pop_ready_in),
    .count_out(count_out), .err_out(err_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string nm, input int cnt, input logic [W-1:0] top, input logic err);
    logic tv, pr;
    tv = cnt != 0;
    pr = cnt != D;
    checks++;
    if (count_out !== CW'(cnt) || top_out !== top || top_valid_out !== tv ||
        push_ready_out !== pr || err_out !== err) begin
      errors++;
      $display("FAIL %s: got count=%0d top=%h tv=%b pr=%b err=%b, want count=%0d top=%h tv=%b pr=%b err=%b",
               nm, count_out, top_out, top_valid_out, push_ready_out, err_out, cnt, top, tv, pr, err);
    end
  endtask
  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.nm, e.cnt, e.top, e.err);
    end
  end
  task automatic step(input logic pv, input logic [W-1:0] d, input logic pp, input logic clr,
                      input string nm, input int cnt, input logic [W-1:0] top, input logic er);
    exp_t e;
    @(negedge clk_in);
    push_valid_in = pv;
    push_data_in  = d;
    pop_ready_in  = pp;
    clear_in      = clr;
    @(posedge clk_in);
    e.nm  = nm;
    e.cnt = cnt;
    e.top = top;
    e.err = EN & er;
    q.push_back(e);
  endtask
  initial begin
    #12;
    chk("reset", 0, '0, 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step(1, 16'h5, 0, 0, "push_a", 1, 16'h5, 0);
    step(1, 16'h9, 0, 0, "push_b", 2, 16'h9, 0);
    step(0, 16'h0, 1, 0, "pop_b", 1, 16'h5, 0);
    step(0, 16'h0, 1, 0, "pop_a", 0, 16'h0, 0);
    step(0, 16'h0, 1, 0, "pop_empty", 0, 16'h0, 1);
    step(0, 16'h0, 0, 0, "err_sticky", 0, 16'h0, 1);
    step(0, 16'h0, 0, 1, "clear_err", 0, 16'h0, 0);
    for (int i = 1; i <= D; i++) step(1, W'(i), 0, 0, $sformatf("fill_%0d", i), i, W'(i), 0);
    step(1, 16'h11, 0, 0, "push_full", 16, 16'h10, 1);
    step(1, 16'h63, 1, 0, "pushpop_full", 15, 16'hf, 1);
    step(1, 16'h55, 1, 1, "clear_push_pop", 0, 16'h0, 0);
    step(1, 16'h1, 0, 0, "load_1", 1, 16'h1, 0);
    step(1, 16'h2, 0, 0, "load_2", 2, 16'h2, 0);
    step(1, 16'h7, 0, 0, "load_7", 3, 16'h7, 0);
    step(1, 16'ha, 1, 0, "replace_top", 3, 16'ha, 0);
    step(0, 16'h0, 1, 0, "pop_after_replace", 2, 16'h2, 0);
    step(1, 16'h3, 0, 0, "load_3", 3, 16'h3, 0);
    step(1, 16'h4, 0, 0, "load_4", 4, 16'h4, 0);
    @(negedge clk_in);
    push_valid_in = 1'b1;
    push_data_in  = 16'h8;
    pop_ready_in  = 1'b0;
    #2 rst_n_in = 1'b0;
    #1 chk("async_reset", 0, '0, 1'b0);
    @(negedge clk_in);
    push_valid_in = 1'b0;
    rst_n_in = 1'b1;
    step(0, 16'h0, 0, 0, "post_reset_idle", 0, 16'h0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
